countdown_timer_32bit: RTL and testbench

Programmable 32-bit countdown timer built from four cascaded 8-bit down-counter stages linked by a borrow chain. It is the decrementing counterpart of the team's cascaded 8-bit up-counter. It loads a start value, decrements once per qualified tick while running, and signals expiry with a one-cycle pulse on reaching zero. It is intended as a macro-friendly timebase for timeouts and periodic events in the workshop designs.

---
 rtl/timer_pkg.sv | 13 +
 rtl/down_counter_8bit.sv | 32 +++
 rtl/countdown_timer_32bit.sv | 138 +++++++++++++
 tb/tb_countdown_timer_32bit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and widths for the cascaded 32-bit countdown timer.
package timer_pkg;

    localparam int STAGE_W    = 8;
    localparam int NUM_STAGES = 4;
    localparam int COUNT_W    = STAGE_W * NUM_STAGES;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/down_counter_8bit.sv
// One 8-bit down-counter stage of the countdown timer; borrow_o enables the next stage.
module down_counter_8bit
    import timer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [STAGE_W-1:0] load_val_i,
    input  logic               en_i,
    output logic [STAGE_W-1:0] count_o,
    output logic               borrow_o
);

    logic [STAGE_W-1:0] count_r;

    // Stage register: load beats decrement, and an enabled 0x00 wraps to 0xFF
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= {STAGE_W{1'b0}};
        end else if (load_i) begin
            count_r <= load_val_i;
        end else if (en_i) begin
            count_r <= count_r - {{(STAGE_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count_o  = count_r;
    assign borrow_o = en_i & (count_r == {STAGE_W{1'b0}});

endmodule

// File: rtl/countdown_timer_32bit.sv
// 32-bit countdown timer: IDLE/RUN control over a borrow-chained stack of 8-bit stages.
// Optional periodic reload is compiled in with `define TIMER_AUTORELOAD_EN.
module countdown_timer_32bit
    import timer_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_i,
    input  logic [STAGE_W*NUM_STAGES-1:0] load_val_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          tick_i,
    output logic [STAGE_W*NUM_STAGES-1:0] count_o,
    output logic                          busy_o,
    output logic                          expire_o
);

    localparam int CNT_W = STAGE_W * NUM_STAGES;
    localparam logic [CNT_W-1:0] COUNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] COUNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    timer_state_e     state_r;
    timer_state_e     state_next_s;
    logic             expire_r;
    logic             expire_next_s;
    logic [CNT_W-1:0] count_s;
    logic             stage0_en_s;
    logic             expire_tick_s;
    logic             reload_hit_s;
    logic [CNT_W-1:0] reload_val_s;
    logic             ctr_load_s;
    logic [CNT_W-1:0] ctr_load_val_s;
    logic             underflow_s;

    assign stage0_en_s   = (state_r == RUN) & tick_i & ~load_i & ~stop_i;
    assign expire_tick_s = stage0_en_s & (count_s == COUNT_ONE);

`ifdef TIMER_AUTORELOAD_EN
    logic [CNT_W-1:0] reload_r;

    // Reload register follows every explicit load
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reload_r <= COUNT_ZERO;
        end else if (load_i) begin
            reload_r <= load_val_i;
        end else begin
            reload_r <= reload_r;
        end
    end

    assign reload_hit_s = expire_tick_s & (reload_r != COUNT_ZERO);
    assign reload_val_s = reload_r;
`else
    assign reload_hit_s = 1'b0;
    assign reload_val_s = COUNT_ZERO;
`endif

    // Expiry reload reuses the stage load path; the stage load overrides its decrement
    assign ctr_load_s     = load_i | reload_hit_s;
    assign ctr_load_val_s = load_i ? load_val_i : reload_val_s;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic               en_s;
        logic               borrow_s;
        logic [STAGE_W-1:0] cnt_s;

        if (k == 0) begin : g_first
            assign en_s = stage0_en_s;
        end else begin : g_next
            assign en_s = g_stage[k-1].borrow_s;
        end

        down_counter_8bit u_stage (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (ctr_load_s),
            .load_val_i (ctr_load_val_s[k*STAGE_W +: STAGE_W]),
            .en_i       (en_s),
            .count_o    (cnt_s),
            .borrow_o   (borrow_s)
        );

        assign count_s[k*STAGE_W +: STAGE_W] = cnt_s;
    end

    // A borrow out of the top stage means the count wrapped past zero; treat it as a fault and stop
    assign underflow_s = g_stage[NUM_STAGES-1].borrow_s;

    // Next-state and expiry decode, priority load > stop > start > tick
    always_comb begin
        state_next_s  = state_r;
        expire_next_s = 1'b0;
        if (load_i) begin
            if ((state_r == RUN) && (load_val_i == COUNT_ZERO)) begin
                state_next_s = IDLE;
            end else begin
                state_next_s = state_r;
            end
        end else if (stop_i) begin
            state_next_s = IDLE;
        end else if (state_r == IDLE) begin
            if (start_i && (count_s != COUNT_ZERO)) begin
                state_next_s = RUN;
            end else if (start_i) begin
                state_next_s  = IDLE;
                expire_next_s = 1'b1;
            end else begin
                state_next_s = IDLE;
            end
        end else if (expire_tick_s) begin
            expire_next_s = 1'b1;
            state_next_s  = reload_hit_s ? RUN : IDLE;
        end else if (underflow_s) begin
            state_next_s = IDLE;
        end else begin
            state_next_s = RUN;
        end
    end

    // State and expiry pulse registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            expire_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            expire_r <= expire_next_s;
        end
    end

    assign count_o  = count_s;
    assign busy_o   = (state_r == RUN);
    assign expire_o = expire_r;

endmodule

// File: tb/tb_countdown_timer_32bit.sv
// Self-checking bench for countdown_timer_32bit: directed scenarios plus random traffic
// against an integer-level reference model (honours TIMER_AUTORELOAD_EN).
module tb_countdown_timer_32bit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        load_i = 1'b0;
    logic [31:0] load_val_i = 32'd0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        tick_i = 1'b0;
    logic [31:0] count_o;
    logic        busy_o;
    logic        expire_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

`ifdef TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    // Reference model state
    logic [31:0] m_cnt = 32'd0;
    logic [31:0] m_reload = 32'd0;
    bit          m_run = 1'b0;
    bit          m_exp = 1'b0;

    countdown_timer_32bit #(.NUM_STAGES(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .tick_i     (tick_i),
        .count_o    (count_o),
        .busy_o     (busy_o),
        .expire_o   (expire_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, written from the timer's rules
    task automatic model_edge(input bit rst, input bit ld, input logic [31:0] val,
                              input bit st, input bit sp, input bit tk);
        if (rst) begin
            m_cnt = 32'd0; m_run = 1'b0; m_exp = 1'b0; m_reload = 32'd0;
        end else begin
            m_exp = 1'b0;
            if (ld) begin
                m_cnt = val;
                m_reload = val;
                if (m_run && val == 32'd0) m_run = 1'b0;
            end else if (sp) begin
                m_run = 1'b0;
            end else if (st && !m_run) begin
                if (m_cnt != 32'd0) m_run = 1'b1;
                else m_exp = 1'b1;
            end else if (m_run && tk) begin
                if (m_cnt == 32'd1) begin
                    m_exp = 1'b1;
                    if (AR && m_reload != 32'd0) m_cnt = m_reload;
                    else begin m_cnt = 32'd0; m_run = 1'b0; end
                end else begin
                    m_cnt = m_cnt - 32'd1;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [31:0] val,
                        input bit st, input bit sp, input bit tk);
        rst_i = rst; load_i = ld; load_val_i = val;
        start_i = st; stop_i = sp; tick_i = tk;
        @(posedge clk_i);
        model_edge(rst, ld, val, st, sp, tk);
        #1;
        check_eq("count", count_o, m_cnt);
        check_eq("busy", {31'd0, busy_o}, {31'd0, m_run});
        check_eq("expire", {31'd0, expire_o}, {31'd0, m_exp});
    endtask

    initial begin
        int exp_seen;
        logic [31:0] v;

        // Reset
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_count", count_o, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);

        // Basic run from 5
        step(1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_eq("basic_start_busy", {31'd0, busy_o}, 32'd1);
        check_eq("basic_start_cnt", count_o, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            check_eq("basic_cnt", count_o, (i < 5) ? 32'(5 - i) : (AR ? 32'd5 : 32'd0));
            check_eq("basic_exp", {31'd0, expire_o}, (i == 5) ? 32'd1 : 32'd0);
            check_eq("basic_busy", {31'd0, busy_o}, (i < 5 || AR) ? 32'd1 : 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Borrow ripple across all stages
        step(1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_eq("borrow_ripple", count_o, 32'h00FF_FFFF);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // stop beats start in IDLE
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        check_eq("stop_start_idle", {31'd0, busy_o}, 32'd0);

        // stop holds the count
        step(1'b0, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check_eq("stop_hold_cnt", count_o, 32'd7);
        check_eq("stop_hold_busy", {31'd0, busy_o}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_eq("idle_tick_ignored", count_o, 32'd7);

        // load with tick in RUN: tick dropped
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        check_eq("load_tick_cnt", count_o, 32'h55);
        check_eq("load_tick_busy", {31'd0, busy_o}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // start at zero pulses expire and stays idle
        step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_eq("start_zero_exp", {31'd0, expire_o}, 32'd1);
        check_eq("start_zero_busy", {31'd0, busy_o}, 32'd0);

        // Reset mid-run
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_eq("midrun_rst_cnt", count_o, 32'd0);
        check_eq("midrun_rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("midrun_rst_exp", {31'd0, expire_o}, 32'd0);

        // Sparse ticks: every 4th cycle
        step(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        exp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, (i % 4) == 3);
            if (expire_o) exp_seen = (i == 11) ? exp_seen + 1 : exp_seen + 100;
        end
        check_eq("sparse_expire_at_3rd_tick", 32'(exp_seen), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Periodic reload (or single expiry without it)
        step(1'b0, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        exp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            if (expire_o) exp_seen++;
        end
        check_eq("reload_pulses", 32'(exp_seen), AR ? 32'd3 : 32'd1);
        check_eq("reload_busy", {31'd0, busy_o}, AR ? 32'd1 : 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(3, 0))
                0: v = 32'($urandom_range(20, 0));
                1: v = $urandom;
                2: v = {8'($urandom_range(3, 0)), 24'd0};
                default: v = 32'($urandom_range(6, 1));
            endcase
            step($urandom_range(199, 0) == 0, $urandom_range(19, 0) == 0, v,
                 $urandom_range(9, 0) == 0, $urandom_range(24, 0) == 0,
                 $urandom_range(1, 0) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
